bmp_pix_unpack: RTL

//  Converts a raw BMP pixel-array byte stream into whole pixels for the video filter chain.

---
 rtl/bmp_pkg.sv | 24 ++
 rtl/bmp_pix_unpack.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/bmp_pkg.sv
// Shared definitions for the BMP pixel-array unpacker: BitCount codes,
// controller state encoding and the row padding helper.
package bmp_pkg;

  localparam logic [5:0] BC_8  = 6'd8;
  localparam logic [5:0] BC_24 = 6'd24;
  localparam logic [5:0] BC_32 = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PAD  = 2'd2,
    ST_DONE = 2'd3
  } bmp_state_t;

  // Rows are stored padded to a multiple of 4 bytes; only the low two bits
  // of the row byte count decide how many filler bytes follow.
  function automatic logic [1:0] bmp_row_pad(input logic [31:0] w, input logic [2:0] bpb);
    logic [33:0] row_bytes;
    row_bytes = {2'b00, w} * {31'd0, bpb};
    return 2'((34'd4 - (row_bytes % 34'd4)) % 34'd4);
  endfunction

endpackage

// File: rtl/bmp_pix_unpack.sv
// Unpacks a raw BMP pixel-array byte stream into whole BGR/BGRA/index pixels,
// dropping row padding and tagging SOF/EOL/EOF with the image row index.
module bmp_pix_unpack
  import bmp_pkg::*;
#(
  parameter int MAX_W     = 4096,
  parameter int MAX_H     = 4096,
  parameter bit BOTTOM_UP = 1'b1,
  localparam int WW = $clog2(MAX_W + 1),
  localparam int HW = $clog2(MAX_H + 1),
  localparam int YW = (MAX_H > 1) ? $clog2(MAX_H) : 1
) (
  input  logic          p_in_clk,
  input  logic          p_in_rst,
  input  logic          p_in_start,
  input  logic [WW-1:0] p_in_cfg_w,
  input  logic [HW-1:0] p_in_cfg_h,
  input  logic [5:0]    p_in_cfg_bc,
  input  logic [7:0]    p_in_byte,
  input  logic          p_in_byte_vld,
  output logic          p_out_byte_rdy,
  output logic [31:0]   p_out_pix,
  output logic          p_out_pix_vld,
  input  logic          p_in_pix_rdy,
  output logic          p_out_sof,
  output logic          p_out_eol,
  output logic          p_out_eof,
  output logic [YW-1:0] p_out_y,
  output logic          p_out_busy,
  output logic          p_out_done,
  output logic          p_out_err,
  output logic [1:0]    p_out_dbg_state
);

  bmp_state_t    state, state_nxt;
  logic [WW-1:0] w_q, x_q;
  logic [HW-1:0] h_q, row_q;
  logic [2:0]    bpb_q;
  logic [1:0]    slot_q, pad_q, pad_cnt_q;
  logic [23:0]   acc_q;
  logic [31:0]   pix_new;

  logic cfg_ok, start_ok, start_bad;
  logic completing, byte_acc, load, drain, pad_acc;
  logic row_end, last_row, pad_last, done_go;

  // Both handshakes are valid/ready: a beat moves on a clock edge where valid
  // and ready are both high; valid never waits on ready, and a presented beat
  // stays stable until it moves.
  assign cfg_ok    = ((p_in_cfg_bc == BC_8) || (p_in_cfg_bc == BC_24) || (p_in_cfg_bc == BC_32))
                     && (p_in_cfg_w != '0) && (p_in_cfg_h != '0);
  assign start_ok  = (state == ST_IDLE) && p_in_start && cfg_ok;
  assign start_bad = (state == ST_IDLE) && p_in_start && !cfg_ok;

  assign completing = (slot_q == 2'(bpb_q - 3'd1));
  assign row_end    = (x_q == w_q - WW'(1));
  assign last_row   = (row_q == h_q - HW'(1));
  assign pad_last   = (pad_cnt_q == pad_q - 2'd1);
  assign drain      = p_out_pix_vld && p_in_pix_rdy;

  // A completing byte may enter only if the output register is empty or is
  // being drained on the same edge.
  assign p_out_byte_rdy = ((state == ST_RUN) && !(completing && p_out_pix_vld && !p_in_pix_rdy))
                          || (state == ST_PAD);
  assign byte_acc = p_in_byte_vld && p_out_byte_rdy;
  assign load     = byte_acc && (state == ST_RUN) && completing;
  assign pad_acc  = byte_acc && (state == ST_PAD);
  assign done_go  = (state == ST_DONE) && (!p_out_pix_vld || p_in_pix_rdy);

  assign p_out_busy      = (state != ST_IDLE);
  assign p_out_dbg_state = state;

  always_comb begin
    pix_new = {p_in_byte, acc_q};
    case (bpb_q)
      3'd1:    pix_new = {24'd0, p_in_byte};
      3'd3:    pix_new = {8'd0, p_in_byte, acc_q[15:0]};
      default: pix_new = {p_in_byte, acc_q};
    endcase
  end

  always_ff @(posedge p_in_clk or posedge p_in_rst) begin
    if (p_in_rst) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_ok) state_nxt = ST_RUN;
      ST_RUN: begin
        if (load && row_end) begin
          if (pad_q != 2'd0) state_nxt = ST_PAD;
          else if (last_row) state_nxt = ST_DONE;
        end
      end
      ST_PAD:  if (pad_acc && pad_last) state_nxt = last_row ? ST_DONE : ST_RUN;
      ST_DONE: if (done_go) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge p_in_clk or posedge p_in_rst) begin
    if (p_in_rst) begin
      w_q           <= '0;
      h_q           <= '0;
      bpb_q         <= '0;
      pad_q         <= '0;
      x_q           <= '0;
      row_q         <= '0;
      slot_q        <= '0;
      pad_cnt_q     <= '0;
      acc_q         <= '0;
      p_out_pix     <= '0;
      p_out_pix_vld <= 1'b0;
      p_out_sof     <= 1'b0;
      p_out_eol     <= 1'b0;
      p_out_eof     <= 1'b0;
      p_out_y       <= '0;
      p_out_done    <= 1'b0;
      p_out_err     <= 1'b0;
    end else begin
      p_out_err  <= start_bad;
      p_out_done <= done_go;

      if (start_ok) begin
        w_q       <= p_in_cfg_w;
        h_q       <= p_in_cfg_h;
        bpb_q     <= p_in_cfg_bc[5:3];
        pad_q     <= bmp_row_pad(32'(p_in_cfg_w), p_in_cfg_bc[5:3]);
        x_q       <= '0;
        row_q     <= '0;
        slot_q    <= '0;
        pad_cnt_q <= '0;
      end

      if (byte_acc && (state == ST_RUN)) begin
        case (slot_q)
          2'd0:    acc_q[7:0]   <= p_in_byte;
          2'd1:    acc_q[15:8]  <= p_in_byte;
          2'd2:    acc_q[23:16] <= p_in_byte;
          default: ;
        endcase
        slot_q <= completing ? 2'd0 : slot_q + 2'd1;
      end

      if (load) begin
        if (row_end) begin
          x_q <= '0;
          if ((pad_q == 2'd0) && !last_row) row_q <= row_q + HW'(1);
        end else begin
          x_q <= x_q + WW'(1);
        end
      end

      if (pad_acc) begin
        pad_cnt_q <= pad_last ? 2'd0 : pad_cnt_q + 2'd1;
        if (pad_last && !last_row) row_q <= row_q + HW'(1);
      end

      // Output register: a load wins over a drain, giving back-to-back pixels.
      if (load) begin
        p_out_pix     <= pix_new;
        p_out_pix_vld <= 1'b1;
        p_out_sof     <= (x_q == '0) && (row_q == '0);
        p_out_eol     <= row_end;
        p_out_eof     <= row_end && last_row;
        p_out_y       <= YW'(BOTTOM_UP ? (h_q - row_q - HW'(1)) : row_q);
      end else if (drain) begin
        p_out_pix_vld <= 1'b0;
      end
    end
  end

endmodule
